// File: rtl/core_pkg.sv
// Shared core definitions: branch-scheduler state encoding, PC defaults
// and the flush-counter helper.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LINK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int unsigned PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned CNT_W        = 3;

    function automatic logic [CNT_W-1:0] cnt_dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_branch_sched_if.sv
// Branch-request, PC/flush and link-register write-back bundle between
// decode/execute, fetch, the register file and the PC scheduler.
interface pc_branch_sched_if
    import core_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) ();

    logic            stall;
    logic            br_imm_req;
    logic [PC_W-1:0] br_imm_tgt;
    logic            br_imm_link;
    logic            br_reg_req;
    logic [PC_W-1:0] br_reg_val;
    logic            br_reg_link;
    logic            br_ack;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            lr_we;
    logic [PC_W-1:0] lr_data;
    logic            lr_ack;
    logic            busy;

    modport master (
        output stall, br_imm_req, br_imm_tgt, br_imm_link,
               br_reg_req, br_reg_val, br_reg_link, lr_ack,
        input  br_ack, pc, flush, lr_we, lr_data, busy
    );

    modport slave (
        input  stall, br_imm_req, br_imm_tgt, br_imm_link,
               br_reg_req, br_reg_val, br_reg_link, lr_ack,
        output br_ack, pc, flush, lr_we, lr_data, busy
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC source select: register branch > immediate branch > sequential
// step; also forms the link value from the branching instruction's PC.
module pc_next_mux #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned LINK_OFF = 1
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_run,
    input  logic            i_stall,
    input  logic            i_reg_req,
    input  logic [PC_W-1:0] i_reg_val,
    input  logic            i_reg_link,
    input  logic            i_imm_req,
    input  logic [PC_W-1:0] i_imm_tgt,
    input  logic            i_imm_link,
    output logic [PC_W-1:0] o_pc_nxt,
    output logic            o_take,
    output logic            o_link,
    output logic [PC_W-1:0] o_lr_val
);

    assign o_lr_val = i_pc + PC_W'(LINK_OFF);

    always_comb begin
        o_pc_nxt = i_pc;
        o_take   = 1'b0;
        o_link   = 1'b0;
        if (i_run) begin
            // A losing simultaneous immediate request gets no ack and must be re-presented.
            if (i_reg_req) begin
                o_pc_nxt = i_reg_val;
                o_take   = 1'b1;
                o_link   = i_reg_link;
            end else if (i_imm_req) begin
                o_pc_nxt = i_imm_tgt;
                o_take   = 1'b1;
                o_link   = i_imm_link;
            end else if (!i_stall) begin
                o_pc_nxt = i_pc + PC_W'(PC_STEP);
            end
        end
    end

endmodule

// File: rtl/pc_branch_sched.sv
// Architectural PC owner: accepts branches, sequences the LR write-back
// handshake and holds fetch in flush for FLUSH_CYC cycles after a taken branch.
module pc_branch_sched
    import core_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     PC_STEP   = 1,
    parameter int unsigned     LINK_OFF  = 1,
    parameter int unsigned     FLUSH_CYC = 2,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
    input logic             clk,
    input logic             rst_n,
    pc_branch_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_flush;
    logic             r_lr_we;
    logic [PC_W-1:0]  r_lr_data;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             w_flush_nxt;
    logic             w_lr_we_nxt;
    logic [PC_W-1:0]  w_lr_data_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_run;
    logic             w_take;
    logic             w_link;
    logic [PC_W-1:0]  w_lr_val;

    assign w_run = (r_state == ST_RUN);

    pc_next_mux #(
        .PC_W     (PC_W),
        .PC_STEP  (PC_STEP),
        .LINK_OFF (LINK_OFF)
    ) u_next (
        .i_pc       (r_pc),
        .i_run      (w_run),
        .i_stall    (bus.stall),
        .i_reg_req  (bus.br_reg_req),
        .i_reg_val  (bus.br_reg_val),
        .i_reg_link (bus.br_reg_link),
        .i_imm_req  (bus.br_imm_req),
        .i_imm_tgt  (bus.br_imm_tgt),
        .i_imm_link (bus.br_imm_link),
        .o_pc_nxt   (w_pc_nxt),
        .o_take     (w_take),
        .o_link     (w_link),
        .o_lr_val   (w_lr_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_flush   <= 1'b0;
            r_lr_we   <= 1'b0;
            r_lr_data <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_flush   <= w_flush_nxt;
            r_lr_we   <= w_lr_we_nxt;
            r_lr_data <= w_lr_data_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flush_nxt   = r_flush;
        w_lr_we_nxt   = r_lr_we;
        w_lr_data_nxt = r_lr_data;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_take) begin
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    if (w_link) begin
                        w_lr_we_nxt   = 1'b1;
                        w_lr_data_nxt = w_lr_val;
                        w_state_nxt   = ST_LINK;
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_LINK: begin
                // Flush time keeps elapsing while the register file is busy.
                w_cnt_nxt = cnt_dec_sat(r_cnt);
                if (bus.lr_ack) begin
                    w_lr_we_nxt = 1'b0;
                    if (r_cnt != '0) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_flush_nxt = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_flush_nxt = 1'b0;
                w_lr_we_nxt = 1'b0;
            end
        endcase
    end

    assign bus.br_ack  = w_take;
    assign bus.pc      = r_pc;
    assign bus.flush   = r_flush;
    assign bus.lr_we   = r_lr_we;
    assign bus.lr_data = r_lr_data;
    assign bus.busy    = !w_run;

endmodule

// File: tb/tb_pc_branch_sched.sv
// Directed bench for pc_branch_sched: sequential stepping, branch priority,
// LR handshake, flush timing, wrap/stall and asynchronous reset.
module tb_pc_branch_sched;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pc_branch_sched_if #(.PC_W(32)) bus ();

    pc_branch_sched #(
        .PC_W      (32),
        .PC_STEP   (1),
        .LINK_OFF  (1),
        .FLUSH_CYC (2),
        .RESET_PC  (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall       = 1'b0;
        bus.br_imm_req  = 1'b0;
        bus.br_imm_tgt  = '0;
        bus.br_imm_link = 1'b0;
        bus.br_reg_req  = 1'b0;
        bus.br_reg_val  = '0;
        bus.br_reg_link = 1'b0;
        bus.lr_ack      = 1'b0;
    endtask

    // Branch to t without link and wait (bounded) until back in RUN.
    task automatic goto_pc(input logic [31:0] t);
        bus.br_imm_req  = 1'b1;
        bus.br_imm_tgt  = t;
        bus.br_imm_link = 1'b0;
        tick();
        bus.br_imm_req  = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.pc !== t) begin
            n_fail++;
            $display("FAIL goto_pc: busy=%b pc=%h, required busy=0 pc=%h", bus.busy, bus.pc, t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_checks++;
        if (bus.pc !== 32'h0 || bus.flush !== 1'b0 || bus.lr_we !== 1'b0 ||
            bus.lr_data !== 32'h0 || bus.br_ack !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h flush=%b lr_we=%b lr_data=%h br_ack=%b busy=%b, required all zero",
                     bus.pc, bus.flush, bus.lr_we, bus.lr_data, bus.br_ack, bus.busy);
        end
        #11;
        rst_n = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i != 0) tick();
            n_checks++;
            if (bus.pc !== 32'(i) || bus.flush !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_step%0d: pc=%h flush=%b busy=%b, required pc=%h flush=0 busy=0",
                         i, bus.pc, bus.flush, bus.busy, 32'(i));
            end
        end
    endtask

    task automatic test_imm_branch();
        logic [31:0] exp_pc [4];
        logic        exp_fl [4];
        exp_pc = '{32'h40, 32'h40, 32'h40, 32'h41};
        exp_fl = '{1'b1, 1'b1, 1'b0, 1'b0};
        goto_pc(32'd10);
        bus.br_imm_req = 1'b1;
        bus.br_imm_tgt = 32'h40;
        #1;
        n_checks++;
        if (bus.br_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_ack: br_ack=%b, required 1", bus.br_ack);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            // During the first flush cycle, present another request: it must be ignored.
            if (i == 0) begin
                bus.br_imm_tgt = 32'h77;
                #1;
                n_checks++;
                if (bus.br_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_ignore_ack: br_ack=%b, required 0", bus.br_ack);
                end
            end else begin
                bus.br_imm_req = 1'b0;
            end
            n_checks++;
            if (bus.pc !== exp_pc[i] || bus.flush !== exp_fl[i] || bus.busy !== exp_fl[i]) begin
                n_fail++;
                $display("FAIL imm_seq%0d: pc=%h flush=%b busy=%b, required pc=%h flush=%b busy=%b",
                         i, bus.pc, bus.flush, bus.busy, exp_pc[i], exp_fl[i], exp_fl[i]);
            end
        end
    endtask

    task automatic test_reg_link_priority();
        goto_pc(32'h20);
        bus.br_reg_req  = 1'b1;
        bus.br_reg_val  = 32'h100;
        bus.br_reg_link = 1'b1;
        bus.br_imm_req  = 1'b1;
        bus.br_imm_tgt  = 32'h55;
        #1;
        n_checks++;
        if (bus.br_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_ack: br_ack=%b, required 1", bus.br_ack);
        end
        tick();
        bus.br_reg_req = 1'b0;
        bus.br_reg_link = 1'b0;
        bus.br_imm_tgt = 32'h99;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            #1;
            n_checks++;
            if (bus.pc !== 32'h100 || bus.lr_we !== 1'b1 || bus.lr_data !== 32'h21 ||
                bus.flush !== 1'b1 || bus.br_ack !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL link_hold%0d: pc=%h lr_we=%b lr_data=%h flush=%b br_ack=%b busy=%b, required 100/1/21/1/0/1",
                         i, bus.pc, bus.lr_we, bus.lr_data, bus.flush, bus.br_ack, bus.busy);
            end
        end
        bus.br_imm_req = 1'b0;
        bus.lr_ack = 1'b1;
        tick();
        bus.lr_ack = 1'b0;
        n_checks++;
        if (bus.lr_we !== 1'b0 || bus.busy !== 1'b0 || bus.flush !== 1'b0 || bus.pc !== 32'h100) begin
            n_fail++;
            $display("FAIL link_done: lr_we=%b busy=%b flush=%b pc=%h, required 0/0/0/100",
                     bus.lr_we, bus.busy, bus.flush, bus.pc);
        end
        tick();
        n_checks++;
        if (bus.pc !== 32'h101) begin
            n_fail++;
            $display("FAIL link_resume: pc=%h, required 101", bus.pc);
        end
    endtask

    task automatic test_imm_link_fast_ack();
        goto_pc(32'h5);
        bus.lr_ack      = 1'b1;
        bus.br_imm_req  = 1'b1;
        bus.br_imm_tgt  = 32'h30;
        bus.br_imm_link = 1'b1;
        tick();
        bus.br_imm_req  = 1'b0;
        bus.br_imm_link = 1'b0;
        n_checks++;
        if (bus.lr_we !== 1'b1 || bus.lr_data !== 32'h6 || bus.flush !== 1'b1 || bus.pc !== 32'h30) begin
            n_fail++;
            $display("FAIL bl_link: lr_we=%b lr_data=%h flush=%b pc=%h, required 1/6/1/30",
                     bus.lr_we, bus.lr_data, bus.flush, bus.pc);
        end
        tick();
        n_checks++;
        if (bus.lr_we !== 1'b0 || bus.flush !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bl_flush: lr_we=%b flush=%b busy=%b, required 0/1/1", bus.lr_we, bus.flush, bus.busy);
        end
        tick();
        bus.lr_ack = 1'b0;
        n_checks++;
        if (bus.flush !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== 32'h30 || bus.lr_data !== 32'h6) begin
            n_fail++;
            $display("FAIL bl_run: flush=%b busy=%b pc=%h lr_data=%h, required 0/0/30/6",
                     bus.flush, bus.busy, bus.pc, bus.lr_data);
        end
    endtask

    task automatic test_wrap_stall();
        goto_pc(32'hFFFF_FFFE);
        tick();
        n_checks++;
        if (bus.pc !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_max: pc=%h, required ffffffff", bus.pc);
        end
        tick();
        n_checks++;
        if (bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: pc=%h, required 0", bus.pc);
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.pc !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: pc=%h, required 0", i, bus.pc);
            end
        end
        // Branches are accepted even while stalled; a target equal to pc still flushes.
        bus.br_imm_req = 1'b1;
        bus.br_imm_tgt = 32'h0;
        #1;
        n_checks++;
        if (bus.br_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_br_ack: br_ack=%b, required 1", bus.br_ack);
        end
        tick();
        bus.br_imm_req = 1'b0;
        n_checks++;
        if (bus.pc !== 32'h0 || bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL same_tgt_flush: pc=%h flush=%b, required 0/1", bus.pc, bus.flush);
        end
        tick();
        tick();
        n_checks++;
        if (bus.flush !== 1'b0 || bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_no_extend: flush=%b pc=%h, required 0/0", bus.flush, bus.pc);
        end
        bus.stall = 1'b0;
        tick();
        n_checks++;
        if (bus.pc !== 32'h1) begin
            n_fail++;
            $display("FAIL unstall_step: pc=%h, required 1", bus.pc);
        end
    endtask

    task automatic test_reset_mid_link();
        goto_pc(32'h20);
        bus.br_reg_req  = 1'b1;
        bus.br_reg_val  = 32'h200;
        bus.br_reg_link = 1'b1;
        tick();
        bus.br_reg_req  = 1'b0;
        bus.br_reg_link = 1'b0;
        n_checks++;
        if (bus.lr_we !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_link: lr_we=%b busy=%b, required 1/1", bus.lr_we, bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.lr_we !== 1'b0 || bus.pc !== 32'h0 || bus.busy !== 1'b0 ||
            bus.flush !== 1'b0 || bus.lr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: lr_we=%b pc=%h busy=%b flush=%b lr_data=%h, required all zero",
                     bus.lr_we, bus.pc, bus.busy, bus.flush, bus.lr_data);
        end
        #10;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.pc !== 32'h1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_step: pc=%h busy=%b, required 1/0", bus.pc, bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_imm_branch();
        test_reg_link_priority();
        test_imm_link_fast_ack();
        test_wrap_stall();
        test_reset_mid_link();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_sched.md
Name: pc_branch_sched

Overview:
- Owns the architectural program counter for the core.
- Each cycle it picks the next-PC source: sequential step, immediate branch (B/Bcond/BL) or register branch (BX/BLX).
- It sequences the link-register write-back to the register file through a req/ack handshake, and holds fetch in flush for a fixed number of cycles after any taken branch.
- It sits between decode/execute (branch requesters) and fetch/register file (consumers).

Parameters:
- PC_W, 32, width of PC, targets and LR
- PC_STEP, 1, sequential increment added to pc each advancing cycle
- LINK_OFF, 1, offset added to the branching instruction's PC to form the LR value
- FLUSH_CYC, 2, fetch-flush cycles after a taken branch (legal 1..7)
- RESET_PC, 0, pc value on reset

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  fetch/execute stall; freezes sequential advance
- br_imm_req  in  1  immediate-branch request (level, one cycle per branch)
- br_imm_tgt  in  PC_W  immediate-branch target
- br_imm_link  in  1  BL: write LR
- br_reg_req  in  1  register-branch request
- br_reg_val  in  PC_W  register-branch target (register contents)
- br_reg_link  in  1  BLX: write LR
- br_ack  out  1  request accepted this cycle (either source)
- pc  out  PC_W  current PC
- flush  out  1  fetch must discard in-flight instruction
- lr_we  out  1  LR write request to register file
- lr_data  out  PC_W  LR value, stable while lr_we high
- lr_ack  in  1  register file accepted LR write
- busy  out  1  high in any state other than RUN

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=RUN, flush=0, lr_we=0, lr_data=0, br_ack=0, busy=0, flush counter=0.
- States: RUN, LINK, FLUSH.
- RUN:
  - Requests are sampled only in RUN, and both are accepted even when stall=1.
  - Priority: br_reg_req > br_imm_req > sequential.
  - A losing simultaneous br_imm_req is dropped; no ack is given and the requester must re-present it.
  - Accepted branch: br_ack=1 combinationally in the accepting cycle. Next edge: pc<=target, flush<=1, counter<=FLUSH_CYC-1.
  - Accepted branch with link=1: also lr_data<=pc+LINK_OFF (old pc, modulo 2^PC_W), lr_we<=1, next state LINK.
  - Accepted branch with link=0: next state FLUSH.
  - No request and stall=0: pc<=pc+PC_STEP, wrapping modulo 2^PC_W.
  - No request and stall=1: pc holds.
- LINK:
  - lr_we and lr_data held until the cycle lr_ack=1.
  - On that edge: lr_we<=0, next state FLUSH if counter>0, else RUN with flush<=0.
  - flush stays 1 throughout LINK. The counter decrements each LINK cycle, saturating at 0.
  - Branch requests are ignored (br_ack=0); pc holds.
- FLUSH:
  - flush=1; counter decrements each cycle.
  - The edge on which counter==0 moves to RUN with flush<=0; pc holds.
  - With FLUSH_CYC=2 and no link, flush is high exactly 2 cycles after the accept edge.
  - stall does not extend the flush.
- lr_ack while lr_we=0: ignored.
- Reset mid-LINK or mid-FLUSH: pending LR write abandoned, all outputs to reset values immediately.
- Branch target equal to current pc: treated as taken (flush applies).
- br_reg_val is used unmodified; the Thumb bit is the decoder's responsibility.

Decomposition:
- Shared package core_pkg: state encoding (ST_RUN, ST_LINK, ST_FLUSH), PC_W default, RESET_PC constant.
- One natural sub-module: pc_next_mux (combinational source select plus increment). The FSM and flush counter stay in the top.

Test Plan:
- Reset then 4 cycles, stall=0 -> pc = 0,1,2,3,4; flush=0, busy=0.
- pc=10, br_imm_req, tgt=0x40, link=0 -> br_ack=1 that cycle; next pc=0x40; flush high exactly 2 cycles; pc stays 0x40 during flush, then increments to 0x41.
- pc=0x20, br_reg_req with val=0x100 and link=1, plus simultaneous br_imm_req -> reg branch wins; pc=0x100; lr_we=1 with lr_data=0x21. Hold lr_ack=0 for 3 cycles -> lr_we, lr_data stable, flush=1. After lr_ack -> lr_we=0, RUN next cycle.
- Branch request during FLUSH or LINK -> br_ack=0; pc unchanged.
- pc=0xFFFFFFFF, stall=0 -> pc wraps to 0. stall=1 for 3 cycles -> pc frozen.
- rst_n low mid-LINK -> lr_we=0, pc=0, state RUN asynchronously, before the next clk edge.
